inst_encoder_loader: RTL

//  Write-side counterpart of the decode stage. Accepts instruction fields over a valid/ready stream.

---
 rtl/inst_encoder_loader.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/inst_encoder_loader.sv
// inst_encoder_loader: takes instruction field bundles from a valid/ready
// stream, checks that each one is legal, packs it into the 32-bit decode
// format and writes it to instruction memory starting at a base address.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, base_addr, count    job launch (sampled only in IDLE)
//   in_valid/in_ready, in_*    field bundle stream
//   imem_we/addr/wdata/gnt     memory write port, held until granted
//   busy, done, err, err_idx, written   job status
module inst_encoder_loader #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [AW-1:0]   base_addr,
  input  logic [AW:0]     count,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [5:0]      in_opc,
  input  logic [4:0]      in_ra,
  input  logic [4:0]      in_rb,
  input  logic [4:0]      in_rd,
  input  logic [10:0]     in_imd,
  output logic            imem_we,
  output logic [AW-1:0]   imem_addr,
  output logic [XLEN-1:0] imem_wdata,
  input  logic            imem_gnt,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [AW:0]     err_idx,
  output logic [AW:0]     written
);

  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [AW-1:0]   base_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   acc_cnt;
  logic [AW-1:0]   wr_ptr;

  logic            start_job;
  logic            accept;
  logic            legal;
  logic            load_word;
  logic            retire;
  logic            last_accept;
  logic            reg_free;

  // Opcode legality; the control opcode additionally restricts its condition field.
  function automatic logic is_legal(input logic [5:0] opc, input logic [4:0] rd);
    if (opc == 6'h0D) begin
      return (rd <= 5'd3);
    end
    return (opc <= 6'h0E) || (opc == 6'h2B) || (opc == 6'h2C);
  endfunction

  // Handshake qualifiers: one output register, refillable in the cycle it retires.
  always_comb begin
    retire      = imem_we && imem_gnt;
    reg_free    = !imem_we || imem_gnt;
    in_ready    = (state == S_LOAD) && reg_free;
    accept      = in_valid && in_ready;
    legal       = is_legal(in_opc, in_rd);
    load_word   = accept && legal;
    last_accept = accept && ((acc_cnt + CW'(1)) == cnt_q);
    start_job   = (state == S_IDLE) && start;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = (count == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (last_accept) begin
          state_nx = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (reg_free) begin
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Registered status flags derived from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nx == S_LOAD) || (state_nx == S_DRAIN);
      done <= (state_nx == S_DONE);
    end
  end

  // Job bookkeeping: latched parameters, accept counter, write pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q  <= '0;
      cnt_q   <= '0;
      acc_cnt <= '0;
      wr_ptr  <= '0;
    end else if (start_job) begin
      base_q  <= base_addr;
      cnt_q   <= count;
      acc_cnt <= '0;
      wr_ptr  <= '0;
    end else begin
      if (accept) begin
        acc_cnt <= acc_cnt + CW'(1);
      end
      if (load_word) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
    end
  end

  // Output write register; address wraps naturally at 2^AW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else if (load_word) begin
      imem_we    <= 1'b1;
      imem_addr  <= base_q + wr_ptr;
      imem_wdata <= XLEN'({in_opc, in_ra, in_rb, in_rd, in_imd});
    end else if (retire) begin
      imem_we    <= 1'b0;
    end
  end

  // Job status: commit counter and first-illegal capture; held until next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      written <= '0;
      err     <= 1'b0;
      err_idx <= '0;
    end else if (start_job) begin
      written <= '0;
      err     <= 1'b0;
      err_idx <= '0;
    end else begin
      if (retire) begin
        written <= written + CW'(1);
      end
      if (accept && !legal) begin
        err <= 1'b1;
        if (!err) begin
          err_idx <= acc_cnt;
        end
      end
    end
  end

endmodule
